pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised program-counter unit with an integrated next-PC selector and a small return-address stack (RAS).
- Owns the fetch address.
- Each cycle it selects one of: sequential increment, PC-relative branch, absolute jump, call, return, or hold (stall).
- Sits in the control path between decode/branch resolution and instruction memory.
- Keeps the existing start-up rule: the first active clock after reset holds the reset vector.

Parameters:
INST_ADDR_WIDTH, 16, width of PC and all address ports
RESET_VECTOR, 0, PC value loaded on reset and held on the first active clock
PC_INC, 1, sequential increment (address units per instruction)
OFFSET_WIDTH, 8, width of signed branch offset
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
stall  in  1  hold PC and RAS this cycle
br_taken  in  1  take PC-relative branch
br_offset  in  OFFSET_WIDTH  signed offset, two's complement
jmp  in  1  absolute jump to jmp_target
call  in  1  jump to jmp_target and push return address
ret  in  1  pop RAS into PC
jmp_target  in  INST_ADDR_WIDTH  absolute target for jmp/call
pc_out  out  INST_ADDR_WIDTH  current fetch address (registered)
pc_plus  out  INST_ADDR_WIDTH  pc_out + PC_INC (combinational)
ras_empty  out  1  RAS holds no entries
ras_full  out  1  RAS holds RAS_DEPTH entries
ret_err  out  1  one-cycle pulse: ret issued while RAS empty
ras_ovf  out  1  sticky: a push occurred while full

Behaviour:
Reset:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst.
- While rst=0: pc_out=RESET_VECTOR, RAS count=0, ras_empty=1, ras_full=0, ret_err=0, ras_ovf=0, first_done=0.

Start-up:
- First rising edge with rst=1: pc_out stays RESET_VECTOR, first_done<=1.
- All control inputs are ignored on that edge; the RAS is unchanged.

Next-PC selection (when first_done=1), priority highest first:
1. stall: pc_out and RAS hold; ret_err=0.
2. ret: if RAS not empty, pc_out<=top and pop. If empty, pc_out<=pc_plus and ret_err=1 for one cycle.
3. call: pc_out<=jmp_target; push pc_plus.
4. jmp: pc_out<=jmp_target.
5. br_taken: pc_out<=pc_out + sign_extend(br_offset).
6. otherwise: pc_out<=pc_plus.

Arithmetic:
- All addition is modulo 2^INST_ADDR_WIDTH; wrap-around is silent.
- br_offset is sign-extended to INST_ADDR_WIDTH before the add.

RAS:
- Circular buffer with a top pointer and a saturating count 0..RAS_DEPTH.
- Push when full: overwrite the oldest entry, count stays RAS_DEPTH, ras_ovf<=1. ras_ovf clears only on reset.
- Only one of push or pop can occur per cycle, because of the priority order.

Latency:
- pc_out updates one clock after the control inputs are sampled.
- ras_empty and ras_full reflect the registered count.

Reset mid-operation:
- Asynchronous; all state returns to reset values immediately.
- The start-up hold cycle is repeated after rst is released.

Decomposition:
- Shared package pc_pkg holds:
  - next-PC select encoding: SEL_HOLD, SEL_RET, SEL_CALL, SEL_JMP, SEL_BR, SEL_SEQ
  - default-width constants
- Sub-module ras_stack (params: width, depth) owns push/pop/overwrite, count, the full/empty flags and the ovf flag.
- pc_unit owns the priority selector, the PC register and the start-up hold.

Test Plan:
- Reset/start-up: RESET_VECTOR=0x0100, release rst, 3 idle clocks -> pc_out 0x0100, 0x0100, 0x0101, 0x0102.
- Branch with sign and wrap: pc_out=0x0005, br_offset=8'hF0 -> 0xFFF5. Then br_offset=8'h10 -> 0x0005.
- Call/return nest: at 0x0010 call 0x0200, then at 0x0200 call 0x0300, then ret, ret -> pc_out 0x0300, 0x0201, 0x0011, with ras_empty=1 at the end.
- RAS overflow: 5 calls with RAS_DEPTH=4 -> ras_full=1, ras_ovf=1. 4 rets return the newest four addresses; the 5th ret gives ret_err pulse and PC increments.
- Priority/stall: assert stall+ret+jmp together -> pc_out unchanged, RAS unchanged. Drop stall -> ret wins over jmp.
- Async reset mid-call: rst low between edges during a call -> pc_out=RESET_VECTOR immediately, RAS empty, ras_ovf cleared.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC select encoding
// and default widths.
package pc_pkg;

  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_OFFSET_W  = 8;
  localparam int DEF_PC_INC    = 1;
  localparam int DEF_RAS_DEPTH = 4;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_RET,
    SEL_CALL,
    SEL_JMP,
    SEL_BR,
    SEL_SEQ
  } pc_sel_e;

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Return-address stack: circular buffer with a saturating count. A push while
// full overwrites the oldest entry and sets the sticky overflow flag.
module ras_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = DEF_ADDR_W,
  parameter int DEPTH = DEF_RAS_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             full,
  output logic             ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0]               top_q, top_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        ovf_q, ovf_d;

  always_comb begin
    mem_d = mem_q;
    top_d = top_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (push) begin
      // Slot above the top is the oldest entry once the buffer is full.
      top_d        = top_q + 1'b1;
      mem_d[top_d] = push_data;
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end else if (pop && cnt_q != '0) begin
      top_d = top_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign top_data = mem_q[top_q];
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_MAX);
  assign ovf      = ovf_q;

endmodule

// File: rtl/pc_unit.sv
// Program counter with priority next-PC selection, start-up hold cycle and
// an attached return-address stack.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                   INST_ADDR_WIDTH = DEF_ADDR_W,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                   PC_INC          = DEF_PC_INC,
  parameter int                   OFFSET_WIDTH    = DEF_OFFSET_W,
  parameter int                   RAS_DEPTH       = DEF_RAS_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       br_taken,
  input  logic [OFFSET_WIDTH-1:0]    br_offset,
  input  logic                       jmp,
  input  logic                       call,
  input  logic                       ret,
  input  logic [INST_ADDR_WIDTH-1:0] jmp_target,
  output logic [INST_ADDR_WIDTH-1:0] pc_out,
  output logic [INST_ADDR_WIDTH-1:0] pc_plus,
  output logic                       ras_empty,
  output logic                       ras_full,
  output logic                       ret_err,
  output logic                       ras_ovf
);

  localparam int AW = INST_ADDR_WIDTH;
  localparam logic [AW-1:0] INC = AW'(PC_INC);

  logic [AW-1:0] pc_q, pc_d;
  logic          first_done_q, first_done_d;
  logic          ret_err_q, ret_err_d;
  logic [AW-1:0] off_ext;
  logic [AW-1:0] ras_top;
  logic          push, pop;
  pc_sel_e       sel;

  assign pc_plus = pc_q + INC;
  assign off_ext = AW'($signed(br_offset));

  always_comb begin
    sel = SEL_SEQ;
    if (!first_done_q || stall) sel = SEL_HOLD;
    else if (ret)               sel = SEL_RET;
    else if (call)              sel = SEL_CALL;
    else if (jmp)               sel = SEL_JMP;
    else if (br_taken)          sel = SEL_BR;
  end

  always_comb begin
    pc_d         = pc_q;
    first_done_d = 1'b1;
    ret_err_d    = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    unique case (sel)
      SEL_HOLD: pc_d = pc_q;
      SEL_RET: begin
        // Return on an empty stack falls through to the next instruction.
        if (ras_empty) begin
          pc_d      = pc_plus;
          ret_err_d = 1'b1;
        end else begin
          pc_d = ras_top;
          pop  = 1'b1;
        end
      end
      SEL_CALL: begin
        pc_d = jmp_target;
        push = 1'b1;
      end
      SEL_JMP: pc_d = jmp_target;
      SEL_BR:  pc_d = pc_q + off_ext;
      default: pc_d = pc_plus;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_VECTOR;
      first_done_q <= 1'b0;
      ret_err_q    <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      first_done_q <= first_done_d;
      ret_err_q    <= ret_err_d;
    end
  end

  ras_stack #(
    .WIDTH (AW),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf       (ras_ovf)
  );

  assign pc_out  = pc_q;
  assign ret_err = ret_err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, async-reset
// sequence, then randomized traffic against a queue-based reference model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall, br_taken, jmp, call, ret;
  logic [7:0]  br_offset;
  logic [15:0] jmp_target;
  logic [15:0] pc_out, pc_plus;
  logic        ras_empty, ras_full, ret_err, ras_ovf;

  int checks = 0;
  int errors = 0;

  pc_unit #(
    .INST_ADDR_WIDTH (16),
    .RESET_VECTOR    (16'h0100),
    .PC_INC          (1),
    .OFFSET_WIDTH    (8),
    .RAS_DEPTH       (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_offset  (br_offset),
    .jmp        (jmp),
    .call       (call),
    .ret        (ret),
    .jmp_target (jmp_target),
    .pc_out     (pc_out),
    .pc_plus    (pc_plus),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full),
    .ret_err    (ret_err),
    .ras_ovf    (ras_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, br;
    logic [7:0]  off;
    logic        jp, cl, rt;
    logic [15:0] tgt;
    logic [15:0] e_pc;
    logic        e_empty, e_full, e_err, e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic br, input logic [7:0] off,
                       input logic jp, input logic cl, input logic rt,
                       input logic [15:0] tgt);
    stall = st; br_taken = br; br_offset = off;
    jmp = jp; call = cl; ret = rt; jmp_target = tgt;
  endtask

  task automatic check_all(input string tag, input logic [15:0] e_pc, input logic e_empty,
                           input logic e_full, input logic e_err, input logic e_ovf);
    chk({tag, " pc_out"},    {16'h0, pc_out},   {16'h0, e_pc});
    chk({tag, " pc_plus"},   {16'h0, pc_plus},  {16'h0, e_pc + 16'd1});
    chk({tag, " ras_empty"}, {31'h0, ras_empty}, {31'h0, e_empty});
    chk({tag, " ras_full"},  {31'h0, ras_full},  {31'h0, e_full});
    chk({tag, " ret_err"},   {31'h0, ret_err},   {31'h0, e_err});
    chk({tag, " ras_ovf"},   {31'h0, ras_ovf},   {31'h0, e_ovf});
  endtask

  task automatic add(input logic st, input logic br, input logic [7:0] off,
                     input logic jp, input logic cl, input logic rt, input logic [15:0] tgt,
                     input logic [15:0] e_pc, input logic e_empty, input logic e_full,
                     input logic e_err, input logic e_ovf);
    vecs.push_back('{st, br, off, jp, cl, rt, tgt, e_pc, e_empty, e_full, e_err, e_ovf});
  endtask

  // Reference model: PC as plain arithmetic, RAS as a bounded queue
  logic [15:0] mpc;
  logic [15:0] mq[$];
  logic        mfirst, merr, movf;

  task automatic model_reset();
    mpc = 16'h0100; mq.delete(); mfirst = 1'b0; merr = 1'b0; movf = 1'b0;
  endtask

  task automatic model_step();
    merr = 1'b0;
    if (!mfirst) mfirst = 1'b1;
    else if (stall) begin end
    else if (ret) begin
      if (mq.size() > 0) mpc = mq.pop_back();
      else begin mpc = mpc + 16'd1; merr = 1'b1; end
    end else if (call) begin
      if (mq.size() == 4) begin void'(mq.pop_front()); movf = 1'b1; end
      mq.push_back(mpc + 16'd1);
      mpc = jmp_target;
    end else if (jmp) mpc = jmp_target;
    else if (br_taken) mpc = mpc + {{8{br_offset[7]}}, br_offset};
    else mpc = mpc + 16'd1;
  endtask

  initial begin
    drive(0, 0, 8'h00, 0, 0, 0, 16'h0000);

    //   st br off    jp cl rt tgt       pc       emp ful err ovf
    add(0, 0, 8'h00, 0, 0, 0, 16'h0000, 16'h0100, 1, 0, 0, 0); // start-up hold
    add(0, 0, 8'h00, 0, 0, 0, 16'h0000, 16'h0101, 1, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 16'h0000, 16'h0102, 1, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 16'h0005, 16'h0005, 1, 0, 0, 0);
    add(0, 1, 8'hF0, 0, 0, 0, 16'h0000, 16'hFFF5, 1, 0, 0, 0); // negative, wraps
    add(0, 1, 8'h10, 0, 0, 0, 16'h0000, 16'h0005, 1, 0, 0, 0); // wraps back
    add(0, 0, 8'h00, 1, 0, 0, 16'h0010, 16'h0010, 1, 0, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 16'h0200, 16'h0200, 0, 0, 0, 0); // nest
    add(0, 0, 8'h00, 0, 1, 0, 16'h0300, 16'h0300, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 16'h0000, 16'h0201, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 1, 16'h0000, 16'h0011, 1, 0, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 16'h1000, 16'h1000, 0, 0, 0, 0); // overflow run
    add(0, 0, 8'h00, 0, 1, 0, 16'h2000, 16'h2000, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 16'h3000, 16'h3000, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 16'h4000, 16'h4000, 0, 1, 0, 0);
    add(0, 0, 8'h00, 0, 1, 0, 16'h5000, 16'h5000, 0, 1, 0, 1);
    add(0, 0, 8'h00, 0, 0, 1, 16'h0000, 16'h4001, 0, 0, 0, 1);
    add(0, 0, 8'h00, 0, 0, 1, 16'h0000, 16'h3001, 0, 0, 0, 1);
    add(0, 0, 8'h00, 0, 0, 1, 16'h0000, 16'h2001, 0, 0, 0, 1);
    add(0, 0, 8'h00, 0, 0, 1, 16'h0000, 16'h1001, 1, 0, 0, 1);
    add(0, 0, 8'h00, 0, 0, 1, 16'h0000, 16'h1002, 1, 0, 1, 1); // empty ret
    add(0, 0, 8'h00, 0, 0, 0, 16'h0000, 16'h1003, 1, 0, 0, 1);
    add(0, 0, 8'h00, 0, 1, 0, 16'h0400, 16'h0400, 0, 0, 0, 1); // priority
    add(1, 0, 8'h00, 1, 0, 1, 16'h0777, 16'h0400, 0, 0, 0, 1);
    add(1, 0, 8'h00, 1, 0, 1, 16'h0777, 16'h0400, 0, 0, 0, 1);
    add(0, 0, 8'h00, 1, 0, 1, 16'h0777, 16'h1004, 1, 0, 0, 1);
    add(0, 1, 8'h20, 1, 0, 0, 16'h0050, 16'h0050, 1, 0, 0, 1);
    add(0, 1, 8'h20, 1, 1, 0, 16'h0060, 16'h0060, 0, 0, 0, 1);
    add(0, 0, 8'h00, 0, 1, 1, 16'h0999, 16'h0051, 1, 0, 0, 1);
    add(1, 0, 8'h00, 0, 0, 1, 16'h0000, 16'h0051, 1, 0, 0, 1); // stalled empty ret

    #12;
    check_all("reset", 16'h0100, 1, 0, 0, 0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].br, vecs[i].off, vecs[i].jp, vecs[i].cl, vecs[i].rt, vecs[i].tgt);
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_empty,
                vecs[i].e_full, vecs[i].e_err, vecs[i].e_ovf);
    end

    // Async reset between edges while a call is presented
    drive(0, 0, 8'h00, 0, 1, 0, 16'h0ABC);
    @(posedge clk); #1;
    chk("pre-reset pc", {16'h0, pc_out}, 32'h0ABC);
    @(negedge clk); rst = 1'b0; #1;
    check_all("async rst", 16'h0100, 1, 0, 0, 0);
    #2 rst = 1'b1;
    drive(0, 0, 8'h00, 1, 0, 0, 16'h0CCC);
    @(posedge clk); #1;
    check_all("rst hold", 16'h0100, 1, 0, 0, 0);
    drive(0, 0, 8'h00, 0, 0, 0, 16'h0000);
    @(posedge clk); #1;
    check_all("rst seq", 16'h0101, 1, 0, 0, 0);

    // Randomized traffic against the reference model
    @(negedge clk); rst = 1'b0; #1;
    model_reset();
    #2 rst = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, 8'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, 16'($urandom));
      model_step();
      @(posedge clk); #1;
      check_all($sformatf("rand%0d", n), mpc, mq.size() == 0, mq.size() == 4, merr, movf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
